gshare_predictor: RTL and testbench

Parametrised next-generation global branch predictor for the fetch/decode front end. It indexes a PHT of 2-bit saturating counters with PC XOR a speculative global history register (GHR), and supplies targets from a tagged direct-mapped BTB. Each prediction carries a history checkpoint down the pipe. On a decode-stage mispredict the GHR is repaired from that checkpoint.

---
 rtl/bp_pkg.sv | 32 +++
 rtl/bp_btb.sv | 54 +++++
 rtl/gshare_predictor.sv | 94 +++++++++
 tb/tb_gshare_predictor.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/bp_pkg.sv
// Shared types and helpers for the gshare branch predictor.
// The 2-bit counter encoding matches the saturating taken/not-taken scale.
package bp_pkg;

  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } ctr2_t;

  localparam ctr2_t PHT_RESET_VAL = WNT;

  function automatic ctr2_t sat_update(input ctr2_t c, input logic taken);
    logic [1:0] v;
    v = c;
    if (taken && v != 2'b11)
      v = v + 2'd1;
    else if (!taken && v != 2'b00)
      v = v - 2'd1;
    return ctr2_t'(v);
  endfunction

  function automatic int log2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n)
      r++;
    return r;
  endfunction

endpackage

// File: rtl/bp_btb.sv
// Direct-mapped tagged branch target buffer: combinational lookup,
// synchronous write, asynchronous clear of the valid bits.
module bp_btb
  import bp_pkg::*;
#(
  parameter int PC_W    = 32,
  parameter int ENTRIES = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [PC_W-1:0] rd_pc,
  output logic            hit,
  output logic [31:0]     rd_target,
  input  logic            wr_en,
  input  logic [PC_W-1:0] wr_pc,
  input  logic [31:0]     wr_target
);

  localparam int IDX_W = log2(ENTRIES);
  localparam int TAG_W = PC_W - IDX_W - 2;

  logic [ENTRIES-1:0] valid;
  logic [TAG_W-1:0]   tag_mem [ENTRIES];
  logic [31:0]        tgt_mem [ENTRIES];

  logic [IDX_W-1:0] rd_idx, wr_idx;
  logic [TAG_W-1:0] rd_tag, wr_tag;
  logic             unused_low_bits;

  assign rd_idx = rd_pc[IDX_W+1:2];
  assign rd_tag = rd_pc[PC_W-1:IDX_W+2];
  assign wr_idx = wr_pc[IDX_W+1:2];
  assign wr_tag = wr_pc[PC_W-1:IDX_W+2];
  assign unused_low_bits = ^{rd_pc[1:0], wr_pc[1:0]};

  assign hit       = valid[rd_idx] && (tag_mem[rd_idx] == rd_tag);
  assign rd_target = tgt_mem[rd_idx];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      valid <= '0;
    else if (wr_en)
      valid[wr_idx] <= 1'b1;
  end

  // Tag/target payload needs no reset: it is only observed through a valid hit.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      tag_mem[wr_idx] <= wr_tag;
      tgt_mem[wr_idx] <= wr_target;
    end
  end

endmodule

// File: rtl/gshare_predictor.sv
// Gshare direction predictor (PC xor speculative GHR into a 2-bit counter PHT)
// with a tagged BTB for targets and checkpoint-based GHR repair on mispredict.
module gshare_predictor
  import bp_pkg::*;
#(
  parameter int PC_W        = 32,
  parameter int HIST_W      = 6,
  parameter int PHT_ENTRIES = 64,
  parameter int BTB_ENTRIES = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              isBranchF,
  input  logic [PC_W-1:0]   pcF,
  output logic              prd,
  output logic [31:0]       prd_addr,
  output logic [HIST_W-1:0] prd_hist,
  input  logic              upd_valid,
  input  logic [PC_W-1:0]   upd_pc,
  input  logic [HIST_W-1:0] upd_hist,
  input  logic              upd_taken,
  input  logic [31:0]       upd_target,
  input  logic              upd_mispredict,
  output logic [31:0]       perf_branches,
  output logic [31:0]       perf_mispredicts
);

  localparam int PHT_IDX_W = log2(PHT_ENTRIES);

  logic [HIST_W-1:0]    ghr;
  ctr2_t                pht [PHT_ENTRIES];
  logic [PHT_IDX_W-1:0] pidx, uidx;
  ctr2_t                pht_rd;
  logic                 btb_hit;
  logic [31:0]          btb_target;
  logic                 recover;

  assign pidx    = pcF[PHT_IDX_W+1:2] ^ PHT_IDX_W'(ghr);
  assign uidx    = upd_pc[PHT_IDX_W+1:2] ^ PHT_IDX_W'(upd_hist);
  assign pht_rd  = pht[pidx];
  assign recover = upd_valid && upd_mispredict;

  assign prd      = isBranchF && btb_hit && pht_rd[1];
  assign prd_addr = prd ? btb_target : 32'd0;
  assign prd_hist = ghr;

  bp_btb #(
    .PC_W    (PC_W),
    .ENTRIES (BTB_ENTRIES)
  ) u_btb (
    .clk       (clk),
    .reset     (reset),
    .rd_pc     (pcF),
    .hit       (btb_hit),
    .rd_target (btb_target),
    .wr_en     (!stall && upd_valid && upd_taken),
    .wr_pc     (upd_pc),
    .wr_target (upd_target)
  );

  // Truncating casts keep the newest HIST_W bits, which also covers HIST_W=1.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      ghr <= '0;
    else if (!stall) begin
      if (recover)
        ghr <= HIST_W'({upd_hist, upd_taken});
      else if (isBranchF)
        ghr <= HIST_W'({ghr, prd});
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < PHT_ENTRIES; i++)
        pht[i] <= PHT_RESET_VAL;
    end else if (!stall && upd_valid) begin
      pht[uidx] <= sat_update(pht[uidx], upd_taken);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      perf_branches    <= '0;
      perf_mispredicts <= '0;
    end else if (!stall && upd_valid) begin
      perf_branches <= perf_branches + 32'd1;
      if (upd_mispredict)
        perf_mispredicts <= perf_mispredicts + 32'd1;
    end
  end

endmodule

// File: tb/tb_gshare_predictor.sv
// Directed and randomized checks of gshare_predictor against an abstract
// model: counters as integers, BTB entries as the full PC that last trained them.
module tb_gshare_predictor;

  localparam int PC_W = 32, HIST_W = 6, PHT_ENTRIES = 64, BTB_ENTRIES = 16;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              stall = 1'b0;
  logic              isBranchF = 1'b0;
  logic [PC_W-1:0]   pcF = '0;
  logic              prd;
  logic [31:0]       prd_addr;
  logic [HIST_W-1:0] prd_hist;
  logic              upd_valid = 1'b0;
  logic [PC_W-1:0]   upd_pc = '0;
  logic [HIST_W-1:0] upd_hist = '0;
  logic              upd_taken = 1'b0;
  logic [31:0]       upd_target = '0;
  logic              upd_mispredict = 1'b0;
  logic [31:0]       perf_branches, perf_mispredicts;

  always #5 clk = ~clk;

  gshare_predictor #(
    .PC_W(PC_W), .HIST_W(HIST_W), .PHT_ENTRIES(PHT_ENTRIES), .BTB_ENTRIES(BTB_ENTRIES)
  ) dut (
    .clk(clk), .reset(reset), .stall(stall), .isBranchF(isBranchF), .pcF(pcF),
    .prd(prd), .prd_addr(prd_addr), .prd_hist(prd_hist),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_hist(upd_hist), .upd_taken(upd_taken),
    .upd_target(upd_target), .upd_mispredict(upd_mispredict),
    .perf_branches(perf_branches), .perf_mispredicts(perf_mispredicts)
  );

  int          m_pht [PHT_ENTRIES];
  bit          m_bv  [BTB_ENTRIES];
  logic [31:0] m_bpc [BTB_ENTRIES];
  logic [31:0] m_btgt[BTB_ENTRIES];
  int          m_ghr;
  int unsigned m_nbr, m_nmis;
  int          total = 0, bad = 0;
  int          txn = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < PHT_ENTRIES; i++) m_pht[i] = 1;
    for (int i = 0; i < BTB_ENTRIES; i++) begin
      m_bv[i] = 0; m_bpc[i] = '0; m_btgt[i] = '0;
    end
    m_ghr = 0; m_nbr = 0; m_nmis = 0;
  endtask

  // A BTB hit means the same word address trained this slot last.
  function automatic bit model_prd(input logic br, input logic [31:0] pc);
    int unsigned wa = pc >> 2;
    int unsigned bi = wa % BTB_ENTRIES;
    int unsigned pi = (wa ^ m_ghr) % PHT_ENTRIES;
    bit hit = m_bv[bi] && ((m_bpc[bi] >> 2) == wa);
    return br && hit && (m_pht[pi] >= 2);
  endfunction

  // Check outputs mid-cycle, then advance the model across the next rising edge.
  task automatic tick(input string tag);
    bit          ep;
    int unsigned bi, ui;
    @(negedge clk);
    ep = model_prd(isBranchF, pcF);
    bi = (pcF >> 2) % BTB_ENTRIES;
    txn++;
    $display("txn %0d %s br=%b pc=%h prd=%b addr=%h hist=%h upd=%b", txn, tag,
             isBranchF, pcF, prd, prd_addr, prd_hist, upd_valid);
    chk({tag, ".prd"}, 32'(prd), 32'(ep));
    chk({tag, ".addr"}, prd_addr, ep ? m_btgt[bi] : 32'd0);
    chk({tag, ".hist"}, 32'(prd_hist), m_ghr);
    chk({tag, ".nbr"}, perf_branches, m_nbr);
    chk({tag, ".nmis"}, perf_mispredicts, m_nmis);
    @(posedge clk);
    if (reset && !stall) begin
      if (upd_valid) begin
        ui = ((upd_pc >> 2) ^ upd_hist) % PHT_ENTRIES;
        m_pht[ui] = upd_taken ? ((m_pht[ui] == 3) ? 3 : m_pht[ui] + 1)
                              : ((m_pht[ui] == 0) ? 0 : m_pht[ui] - 1);
        if (upd_taken) begin
          bi = (upd_pc >> 2) % BTB_ENTRIES;
          m_bv[bi] = 1; m_bpc[bi] = upd_pc; m_btgt[bi] = upd_target;
        end
        m_nbr++;
        if (upd_mispredict) m_nmis++;
      end
      if (upd_valid && upd_mispredict)
        m_ghr = ((int'(upd_hist) << 1) | int'(upd_taken)) & ((1 << HIST_W) - 1);
      else if (isBranchF)
        m_ghr = ((m_ghr << 1) | int'(ep)) & ((1 << HIST_W) - 1);
    end
    #1;
  endtask

  task automatic look(input string tag, input logic [31:0] pc, input logic ep, input logic [31:0] ea);
    isBranchF = 1'b1; pcF = pc;
    #1;
    chk({tag, ".prd"}, 32'(prd), 32'(ep));
    chk({tag, ".addr"}, prd_addr, ea);
    isBranchF = 1'b0;
  endtask

  task automatic set_upd(input logic v, input logic [31:0] pc, input logic [5:0] h,
                         input logic t, input logic [31:0] tgt, input logic mis);
    upd_valid = v; upd_pc = pc; upd_hist = h; upd_taken = t;
    upd_target = tgt; upd_mispredict = mis;
  endtask

  initial begin
    int unsigned save_nmis, save_nbr;
    int          save_ghr;
    model_reset();

    // Reset state
    isBranchF = 1'b1; pcF = 32'h40;
    #1;
    chk("rst_hold.prd", 32'(prd), 32'd0);
    chk("rst_hold.hist", 32'(prd_hist), 32'd0);
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;
    look("rst_rel", 32'h40, 1'b0, 32'd0);
    chk("rst_rel.hist", 32'(prd_hist), 32'd0);

    // Training: 01 -> 10 -> 11
    set_upd(1, 32'h40, 6'd0, 1, 32'h100, 0);
    tick("train1"); tick("train2");
    set_upd(0, 32'h0, 6'd0, 0, 32'h0, 0);
    look("trained", 32'h40, 1'b1, 32'h100);

    // Saturation: 3 taken stays 11, one not-taken -> 10
    set_upd(1, 32'h40, 6'd0, 1, 32'h100, 0);
    tick("sat_t1"); tick("sat_t2"); tick("sat_t3");
    set_upd(1, 32'h40, 6'd0, 0, 32'h0, 0);
    tick("sat_nt1");
    set_upd(0, 32'h0, 6'd0, 0, 32'h0, 0);
    look("sat_wt", 32'h40, 1'b1, 32'h100);
    set_upd(1, 32'h40, 6'd0, 0, 32'h0, 0);
    tick("sat_nt2"); tick("sat_nt3");
    set_upd(0, 32'h0, 6'd0, 0, 32'h0, 0);
    look("sat_snt", 32'h40, 1'b0, 32'd0);

    // Mispredict recovery wins over a same-cycle fetch shift
    set_upd(1, 32'h80, 6'b000001, 1, 32'h300, 1);
    tick("rec_set");
    chk("rec_set.hist", 32'(prd_hist), 32'b000011);
    save_nmis = m_nmis;
    isBranchF = 1'b1; pcF = 32'h40;
    set_upd(1, 32'h80, 6'b000001, 0, 32'h0, 1);
    tick("recover");
    isBranchF = 1'b0;
    set_upd(0, 32'h0, 6'd0, 0, 32'h0, 0);
    chk("recover.hist", 32'(prd_hist), 32'b000010);
    chk("recover.nmis", perf_mispredicts, save_nmis + 1);

    // Stall freezes all state
    save_ghr = m_ghr; save_nbr = m_nbr; save_nmis = m_nmis;
    stall = 1'b1;
    for (int i = 0; i < 5; i++) begin
      isBranchF = 1'b1; pcF = 32'h40;
      set_upd(1, 32'h40 + 32'(i) * 4, 6'($urandom), 1, $urandom & ~32'h3, 1);
      tick("stall");
    end
    stall = 1'b0; isBranchF = 1'b0;
    set_upd(0, 32'h0, 6'd0, 0, 32'h0, 0);
    chk("stall.hist", 32'(prd_hist), save_ghr);
    chk("stall.nbr", perf_branches, save_nbr);
    chk("stall.nmis", perf_mispredicts, save_nmis);

    // BTB alias: 0x40 and 0x440 share BTB slot 0 and the PHT entry
    set_upd(1, 32'h40, 6'(m_ghr), 1, 32'h100, 0);
    tick("alias_t1"); tick("alias_t2");
    set_upd(0, 32'h0, 6'd0, 0, 32'h0, 0);
    look("alias_hit", 32'h40, 1'b1, 32'h100);
    look("alias_miss", 32'h440, 1'b0, 32'd0);
    set_upd(1, 32'h440, 6'(m_ghr), 1, 32'h200, 0);
    tick("alias_evict");
    set_upd(0, 32'h0, 6'd0, 0, 32'h0, 0);
    look("alias_old", 32'h40, 1'b0, 32'd0);
    look("alias_new", 32'h440, 1'b1, 32'h200);

    // Randomized traffic over a small aliasing PC set
    for (int i = 0; i < 300; i++) begin
      stall     = ($urandom_range(0, 9) == 0);
      isBranchF = $urandom_range(0, 1);
      pcF       = (32'($urandom_range(0, 3)) << 10) | (32'($urandom_range(0, 15)) << 2);
      set_upd($urandom_range(0, 1),
              (32'($urandom_range(0, 3)) << 10) | (32'($urandom_range(0, 15)) << 2),
              6'($urandom), $urandom_range(0, 1), $urandom & ~32'h3,
              ($urandom_range(0, 3) == 0));
      tick("rand");
    end
    stall = 1'b0;

    // Asynchronous reset between edges
    isBranchF = 1'b1; pcF = 32'h440;
    set_upd(0, 32'h0, 6'd0, 0, 32'h0, 0);
    #1 reset = 1'b0;
    #1;
    chk("async_rst.prd", 32'(prd), 32'd0);
    chk("async_rst.addr", prd_addr, 32'd0);
    chk("async_rst.hist", 32'(prd_hist), 32'd0);
    chk("async_rst.nbr", perf_branches, 32'd0);
    chk("async_rst.nmis", perf_mispredicts, 32'd0);
    model_reset();
    isBranchF = 1'b0;
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;
    isBranchF = 1'b1; pcF = 32'h440;
    tick("post_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
